board_compositor: RTL and testbench
===================================

BOARD_COMPOSITOR -- requirements
Module: board_compositor

Interface
REQ-001 The block SHALL have these parameters: COLS, default 16, grid columns; ROWS, default 16, grid rows; CELL_PX, default 6, cell edge in pixels; ORG_X, default 32, grid left pixel; ORG_Y, default 17, grid top pixel; COLOR_W, default 3, colour width; TRANSP, default 0, sprite colour treated as transparent; BLINK_FRAMES, default 30, frames per cursor blink phase; HOLD_FRAMES, default 60, frames the board stays visible after game end.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset, with these ports (name, direction, width, meaning):
- VGA_CLK, in, 1, pixel clock.
- rst_n, in, 1, synchronous active-low reset.
- xvga, in, 8, pixel x.
- yvga, in, 7, pixel y.
- pix_valid, in, 1, visible pixel qualifier.
- cursor_col, in, clog2(COLS), cursor column.
- cursor_row, in, clog2(ROWS), cursor row.
- g_state, in, 2, game state: 0 play, 1 won, 2 lost, 3 reserved (treated as lost).
- start, in, 1, leave the splash screen.
- spr_x, out, 3, cursor ROM column.
- spr_y, out, 3, cursor ROM row.
- spr_color, in, COLOR_W, cursor ROM data, 1-cycle latency.
- bg_color, splash_color, won_color, lost_color, in, COLOR_W each, ROM data, 1-cycle latency, addressed externally by xvga/yvga.
- color, out, COLOR_W, composited pixel.
- frame_tick, out, 1, one-cycle pulse at frame start.
- mode, out, 2, current FSM state encoding.

Function
REQ-003 Frame start SHALL be pix_valid with xvga==0 and yvga==0; frame_tick SHALL assert on the following cycle for one cycle.
REQ-004 cursor_col and cursor_row SHALL be latched only at frame start, so that a cursor move takes effect on the next frame without tearing.
REQ-005 The cursor rectangle SHALL span cx=ORG_X+col*CELL_PX to cx+CELL_PX-1 horizontally, and likewise vertically using ORG_Y and row; the inclusive low bound and exclusive high bound SHALL be evaluated at full width with no wrap.
REQ-006 spr_x and spr_y SHALL be combinational from the current xvga/yvga minus the latched rectangle origin, truncated to 3 bits.
REQ-007 Latency from xvga/yvga to color SHALL be exactly 2 cycles: stage 1 registers in_cursor alongside the ROM responses; stage 2 registers color.
REQ-008 The FSM SHALL have states SPLASH(0), PLAY(1), HOLD(2) and END(3).
- SPLASH goes to PLAY on start.
- PLAY goes to HOLD when g_state!=0.
- HOLD goes to END after HOLD_FRAMES frame ticks.
- HOLD or END goes to SPLASH when start is asserted together with g_state==0.
- HOLD goes back to PLAY when g_state returns to 0 without start.
REQ-009 Colour selection SHALL be:
- SPLASH: splash_color.
- END: won_color if g_state==1, otherwise lost_color.
- PLAY and HOLD: spr_color if in_cursor, the cursor is visible and spr_color!=TRANSP; otherwise bg_color.
REQ-010 When pix_valid is low, color SHALL be 0 after the 2-cycle latency.
REQ-011 FSM transitions SHALL take effect only at frame start, except the start-driven exits, which take effect immediately.
REQ-012 The HOLD frame counter SHALL saturate at HOLD_FRAMES and clear on entering HOLD.
REQ-013 When a cursor at the last column or last row places the rectangle beyond the 8-bit/7-bit screen range, in_cursor SHALL be 0 for the pixels out of range and color SHALL never wrap to the screen origin.

Reset
REQ-014 While rst_n is low at a VGA_CLK edge:
- FSM SHALL go to SPLASH.
- color, frame_tick and both pipeline stages SHALL clear to 0.
- Latched cursor SHALL clear to (0,0).
- Blink and hold counters SHALL clear to 0.
- Cursor SHALL be visible.
REQ-015 A reset during HOLD or END SHALL discard the counters; the block SHALL restart in SPLASH regardless of g_state.

Configuration
REQ-016 With BOARD_COMPOSITOR_BLINK_EN defined, a frame counter SHALL toggle cursor visibility every BLINK_FRAMES frame ticks in PLAY, and SHALL reset visibility to on whenever the latched cursor position changes.
REQ-017 Without BOARD_COMPOSITOR_BLINK_EN, the cursor SHALL be always visible and no blink counter SHALL exist.

Structure
REQ-018 A shared package SHALL hold the FSM state enum, the g_state codes (PLAY/WON/LOST) and the default ORG/CELL constants.
REQ-019 One sub-module, cell_locator, SHALL hold the frame-start latch, the rectangle compare and the spr_x/spr_y offsets; the FSM, counters and colour mux SHALL stay in the top level.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then start, cursor (0,0), pixel (32,17), spr_color=5 -> color=5 two cycles later; pixel (38,17) -> bg_color.
- spr_color=TRANSP inside the cursor -> bg_color shown.
- cursor_col changes mid-frame from 3 to 4 -> rectangle stays at x=50..55 until the next frame_tick, then moves to 56..61.
- g_state=2 in PLAY -> HOLD for 60 frame ticks with the board visible, then END showing lost_color; start with g_state=0 -> SPLASH.
- rst_n low during END -> color=0 next cycle, mode=SPLASH; splash_color shown after release.
- BLINK_EN, BLINK_FRAMES=2 -> cursor visible frames 0-1, hidden 2-3, visible 4-5; a move re-shows it immediately.

Source files
------------

// File: rtl/board_compositor_pkg.sv
// Shared types and constants for the board compositor: FSM states, game-state codes, grid geometry.
package board_compositor_pkg;

  typedef enum logic [1:0] {
    ST_SPLASH = 2'd0,
    ST_PLAY   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_END    = 2'd3
  } state_t;

  localparam logic [1:0] GS_PLAY = 2'd0;
  localparam logic [1:0] GS_WON  = 2'd1;
  localparam logic [1:0] GS_LOST = 2'd2;

  localparam int DEF_COLS    = 16;
  localparam int DEF_ROWS    = 16;
  localparam int DEF_CELL_PX = 6;
  localparam int DEF_ORG_X   = 32;
  localparam int DEF_ORG_Y   = 17;

endpackage

// File: rtl/board_compositor_cell_locator.sv
// Frame-start detect, per-frame cursor latch, cursor-rectangle hit test and sprite ROM offsets.
// Under BOARD_COMPOSITOR_BLINK_EN it also flags a change of the latched cursor position.
module cell_locator
  import board_compositor_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int CELL_PX = DEF_CELL_PX,
  parameter int ORG_X   = DEF_ORG_X,
  parameter int ORG_Y   = DEF_ORG_Y
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              i_x,
  input  logic [6:0]              i_y,
  input  logic                    i_pix_valid,
  input  logic [$clog2(COLS)-1:0] i_col,
  input  logic [$clog2(ROWS)-1:0] i_row,
  output logic                    o_frame_start,
  output logic                    o_in_cursor,
`ifdef BOARD_COMPOSITOR_BLINK_EN
  output logic                    o_moved,
`endif
  output logic [2:0]              o_spr_x,
  output logic [2:0]              o_spr_y
);

  localparam int FW = 16;

  logic [$clog2(COLS)-1:0] r_col;
  logic [$clog2(ROWS)-1:0] r_row;
  logic [FW-1:0]           w_cx;
  logic [FW-1:0]           w_cy;
  logic [FW-1:0]           w_x;
  logic [FW-1:0]           w_y;
  logic                    w_hit_x;
  logic                    w_hit_y;

  assign o_frame_start = i_pix_valid && (i_x == 8'd0) && (i_y == 7'd0);

  // Position is only sampled at frame start so a move never tears a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (o_frame_start) begin
      r_col <= i_col;
      r_row <= i_row;
    end
  end

  // Wide arithmetic keeps an off-screen rectangle from aliasing onto the origin.
  assign w_cx    = FW'(ORG_X) + FW'(r_col) * FW'(CELL_PX);
  assign w_cy    = FW'(ORG_Y) + FW'(r_row) * FW'(CELL_PX);
  assign w_x     = {8'd0, i_x};
  assign w_y     = {9'd0, i_y};
  assign w_hit_x = (w_x >= w_cx) && (w_x < w_cx + FW'(CELL_PX));
  assign w_hit_y = (w_y >= w_cy) && (w_y < w_cy + FW'(CELL_PX));

  assign o_in_cursor = w_hit_x && w_hit_y;
  assign o_spr_x     = i_x[2:0] - w_cx[2:0];
  assign o_spr_y     = i_y[2:0] - w_cy[2:0];

`ifdef BOARD_COMPOSITOR_BLINK_EN
  assign o_moved = o_frame_start && ((i_col != r_col) || (i_row != r_row));
`endif

endmodule

// File: rtl/board_compositor.sv
// Board compositor: splash/play/hold/end FSM and a 2-stage colour pipeline over external ROMs.
// Optional cursor blink is enabled by defining BOARD_COMPOSITOR_BLINK_EN.
module board_compositor
  import board_compositor_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int CELL_PX      = DEF_CELL_PX,
  parameter int ORG_X        = DEF_ORG_X,
  parameter int ORG_Y        = DEF_ORG_Y,
  parameter int COLOR_W      = 3,
  parameter int TRANSP       = 0,
  parameter int BLINK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 60
) (
  input  logic                    VGA_CLK,
  input  logic                    rst_n,
  input  logic [7:0]              xvga,
  input  logic [6:0]              yvga,
  input  logic                    pix_valid,
  input  logic [$clog2(COLS)-1:0] cursor_col,
  input  logic [$clog2(ROWS)-1:0] cursor_row,
  input  logic [1:0]              g_state,
  input  logic                    start,
  output logic [2:0]              spr_x,
  output logic [2:0]              spr_y,
  input  logic [COLOR_W-1:0]      spr_color,
  input  logic [COLOR_W-1:0]      bg_color,
  input  logic [COLOR_W-1:0]      splash_color,
  input  logic [COLOR_W-1:0]      won_color,
  input  logic [COLOR_W-1:0]      lost_color,
  output logic [COLOR_W-1:0]      color,
  output logic                    frame_tick,
  output logic [1:0]              mode
);

  localparam int                 HW        = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0]      HOLD_MAX  = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [COLOR_W-1:0] TRANSP_C  = COLOR_W'(TRANSP);

  state_t             r_state;
  logic [HW-1:0]      r_hold_cnt;
  logic               r_frame_tick;
  logic               r_valid1;
  logic               r_in_cursor1;
  logic [COLOR_W-1:0] r_color;
  logic [COLOR_W-1:0] w_color_next;
  logic               w_frame_start;
  logic               w_in_cursor;
  logic               w_visible;
  logic               w_restart;
`ifdef BOARD_COMPOSITOR_BLINK_EN
  logic               w_moved;
`endif

  cell_locator #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .CELL_PX (CELL_PX),
    .ORG_X   (ORG_X),
    .ORG_Y   (ORG_Y)
  ) u_cell_locator (
    .clk           (VGA_CLK),
    .rst_n         (rst_n),
    .i_x           (xvga),
    .i_y           (yvga),
    .i_pix_valid   (pix_valid),
    .i_col         (cursor_col),
    .i_row         (cursor_row),
    .o_frame_start (w_frame_start),
    .o_in_cursor   (w_in_cursor),
`ifdef BOARD_COMPOSITOR_BLINK_EN
    .o_moved       (w_moved),
`endif
    .o_spr_x       (spr_x),
    .o_spr_y       (spr_y)
  );

  assign w_restart = start && (g_state == GS_PLAY);

  // Start-driven exits act immediately; every other transition waits for frame start.
  always_ff @(posedge VGA_CLK) begin
    if (!rst_n) begin
      r_state    <= ST_SPLASH;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_SPLASH: if (start) r_state <= ST_PLAY;
        ST_PLAY: begin
          if (w_frame_start && (g_state != GS_PLAY)) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (w_restart) begin
            r_state <= ST_SPLASH;
          end else if (w_frame_start) begin
            if (g_state == GS_PLAY) begin
              r_state <= ST_PLAY;
            end else begin
              if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + 1'b1;
              if (r_hold_cnt >= HOLD_LAST) r_state <= ST_END;
            end
          end
        end
        ST_END:  if (w_restart) r_state <= ST_SPLASH;
        default: r_state <= ST_SPLASH;
      endcase
    end
  end

`ifdef BOARD_COMPOSITOR_BLINK_EN
  localparam int            BW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_visible;

  always_ff @(posedge VGA_CLK) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
    end else if ((r_state == ST_SPLASH) && start) begin
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
    end else if ((r_state == ST_PLAY) && w_frame_start) begin
      if (w_moved) begin
        r_blink_cnt <= '0;
        r_visible   <= 1'b1;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_visible   <= ~r_visible;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_visible = r_visible;
`else
  assign w_visible = 1'b1;
`endif

  // ROM data arrives one cycle after the address, aligned with the stage-1 registers.
  always_comb begin
    w_color_next = '0;
    if (r_valid1) begin
      case (r_state)
        ST_SPLASH: w_color_next = splash_color;
        ST_END:    w_color_next = (g_state == GS_WON) ? won_color : lost_color;
        default:   w_color_next = (r_in_cursor1 && w_visible && (spr_color != TRANSP_C))
                                  ? spr_color : bg_color;
      endcase
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (!rst_n) begin
      r_frame_tick <= 1'b0;
      r_valid1     <= 1'b0;
      r_in_cursor1 <= 1'b0;
      r_color      <= '0;
    end else begin
      r_frame_tick <= w_frame_start;
      r_valid1     <= pix_valid;
      r_in_cursor1 <= w_in_cursor;
      r_color      <= w_color_next;
    end
  end

  assign color      = r_color;
  assign frame_tick = r_frame_tick;
  assign mode       = r_state;

endmodule

// File: tb/tb_board_compositor.sv
// Directed bench for board_compositor with a scoreboard queue aligned to the 2-cycle colour latency.
`timescale 1ns/1ps
module tb_board_compositor;
  import board_compositor_pkg::*;

`ifdef BOARD_COMPOSITOR_BLINK_EN
  localparam int BLINK = 2;
`else
  localparam int BLINK = 30;
`endif
  localparam int BG = 1, SPL = 2, WON = 3, LOST = 4, SPR = 5, NOCHK = -1;

  logic       VGA_CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] xvga = 8'd0;
  logic [6:0] yvga = 7'd0;
  logic       pix_valid = 1'b1;
  logic [3:0] cursor_col = 4'd0;
  logic [3:0] cursor_row = 4'd0;
  logic [1:0] g_state = 2'd0;
  logic       start = 1'b0;
  logic [2:0] spr_x, spr_y;
  logic [2:0] spr_color = 3'd0;
  logic [2:0] spr_val = 3'(SPR);
  logic [2:0] color;
  logic       frame_tick;
  logic [1:0] mode;

  typedef struct { int exp; string tag; } sb_t;
  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass = 0;

  board_compositor #(.BLINK_FRAMES(BLINK)) dut (
    .VGA_CLK(VGA_CLK), .rst_n(rst_n), .xvga(xvga), .yvga(yvga), .pix_valid(pix_valid),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .g_state(g_state), .start(start),
    .spr_x(spr_x), .spr_y(spr_y), .spr_color(spr_color),
    .bg_color(3'(BG)), .splash_color(3'(SPL)), .won_color(3'(WON)), .lost_color(3'(LOST)),
    .color(color), .frame_tick(frame_tick), .mode(mode)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // Sprite ROM model: one-cycle read latency.
  always @(posedge VGA_CLK) spr_color <= spr_val;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s ok: %0d", tag, obs);
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: compare the pixel issued two steps ago, drive a new one, advance a cycle.
  task automatic step(input logic [7:0] x, input logic [6:0] y, input int exp, input string tag);
    sb_t e;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.exp >= 0) check(e.tag, 8'(color), 8'(e.exp));
    end
    xvga = x;
    yvga = y;
    sb.push_back('{exp: exp, tag: tag});
    @(negedge VGA_CLK);
  endtask

  // Enter HOLD on the current frame start, then run until END (cursor sits at cell 15,15).
  task automatic hold_to_end(input string tag);
    g_state = 2'd2;
    step(8'd0, 7'd0, BG, {tag, "_entry"});
    check({tag, "_mode_hold"}, 8'(mode), 8'(ST_HOLD));
    for (int f = 1; f < 60; f++) begin
      step(8'd0, 7'd0, BG, {tag, "_hold_fs"});
      step(8'd122, 7'd107, SPR, {tag, "_hold_cur"});
      step(8'd1, 7'd1, BG, {tag, "_hold_bg"});
    end
    check({tag, "_still_hold"}, 8'(mode), 8'(ST_HOLD));
    step(8'd0, 7'd0, NOCHK, "");
    check({tag, "_mode_end"}, 8'(mode), 8'(ST_END));
  endtask

  initial begin
    repeat (3) @(negedge VGA_CLK);
    check("rst_mode", 8'(mode), 8'(ST_SPLASH));
    check("rst_color", 8'(color), 8'd0);
    check("rst_ftick", 8'(frame_tick), 8'd0);
    rst_n = 1'b1;

    step(8'd0, 7'd0, SPL, "splash_fs");
    check("ftick_hi", 8'(frame_tick), 8'd1);
    step(8'd1, 7'd0, SPL, "splash_px");
    check("ftick_lo", 8'(frame_tick), 8'd0);

    start = 1'b1;
    step(8'd5, 7'd5, NOCHK, "");
    start = 1'b0;
    check("mode_play", 8'(mode), 8'(ST_PLAY));
    step(8'd0, 7'd0, BG, "play_fs");
    step(8'd32, 7'd17, SPR, "cur_tl");
    check("sprx_tl", 8'(spr_x), 8'd0);
    check("spry_tl", 8'(spr_y), 8'd0);
    step(8'd34, 7'd19, SPR, "cur_mid");
    check("sprx_mid", 8'(spr_x), 8'd2);
    check("spry_mid", 8'(spr_y), 8'd2);
    step(8'd37, 7'd22, SPR, "cur_br");
    step(8'd38, 7'd17, BG, "right_out");
    step(8'd32, 7'd23, BG, "below_out");
    step(8'd31, 7'd17, BG, "left_out");
    pix_valid = 1'b0;
    step(8'd32, 7'd17, 0, "blank");
    pix_valid = 1'b1;
    spr_val = 3'd0;
    step(8'd33, 7'd18, BG, "transp");
    spr_val = 3'(SPR);

    cursor_col = 4'd3;
    step(8'd0, 7'd0, BG, "fs_col3");
    step(8'd50, 7'd17, SPR, "c3_lo");
    step(8'd55, 7'd17, SPR, "c3_hi");
    step(8'd56, 7'd17, BG, "c3_out");
    cursor_col = 4'd4;
    step(8'd50, 7'd17, SPR, "c4pend_lo");
    step(8'd56, 7'd17, BG, "c4pend_hi");
    step(8'd0, 7'd0, BG, "fs_col4");
    check("ftick_col4", 8'(frame_tick), 8'd1);
    step(8'd50, 7'd17, BG, "c4_old");
    step(8'd56, 7'd17, SPR, "c4_lo");
    step(8'd61, 7'd17, SPR, "c4_hi");
    step(8'd62, 7'd17, BG, "c4_out");

    cursor_col = 4'd15;
    cursor_row = 4'd15;
    step(8'd0, 7'd0, BG, "fs_last");
    step(8'd122, 7'd107, SPR, "last_tl");
    step(8'd127, 7'd112, SPR, "last_br");
    step(8'd121, 7'd112, BG, "last_left");
    step(8'd127, 7'd106, BG, "last_above");
    step(8'd127, 7'd113, BG, "last_below");

    g_state = 2'd2;
    step(8'd1, 7'd1, BG, "gs2_midframe");
    check("no_early_hold", 8'(mode), 8'(ST_PLAY));
    hold_to_end("h1");
    step(8'd1, 7'd1, LOST, "end_lost");
    step(8'd122, 7'd107, LOST, "end_lost_cur");
    step(8'd2, 7'd2, NOCHK, "");
    g_state = 2'd1;
    step(8'd1, 7'd1, WON, "end_won");
    step(8'd2, 7'd2, NOCHK, "");
    g_state = 2'd3;
    step(8'd1, 7'd1, LOST, "end_reserved");
    step(8'd2, 7'd2, NOCHK, "");

    g_state = 2'd0;
    start = 1'b1;
    step(8'd1, 7'd1, NOCHK, "");
    start = 1'b0;
    check("end_to_splash", 8'(mode), 8'(ST_SPLASH));
    step(8'd1, 7'd1, SPL, "back_splash");

    start = 1'b1;
    step(8'd5, 7'd5, NOCHK, "");
    start = 1'b0;
    g_state = 2'd2;
    step(8'd0, 7'd0, NOCHK, "");
    check("h2_hold", 8'(mode), 8'(ST_HOLD));
    g_state = 2'd0;
    step(8'd1, 7'd1, NOCHK, "");
    check("hold_wait_fs", 8'(mode), 8'(ST_HOLD));
    step(8'd0, 7'd0, NOCHK, "");
    check("hold_to_play", 8'(mode), 8'(ST_PLAY));
    hold_to_end("h3");
    step(8'd1, 7'd1, LOST, "h3_end_lost");

    rst_n = 1'b0;
    @(posedge VGA_CLK);
    #1;
    check("rst_end_color", 8'(color), 8'd0);
    check("rst_end_mode", 8'(mode), 8'(ST_SPLASH));
    sb.delete();
    @(negedge VGA_CLK);
    @(negedge VGA_CLK);
    rst_n = 1'b1;
    step(8'd1, 7'd1, SPL, "post_rst_splash");
    step(8'd0, 7'd0, SPL, "post_rst_fs");
    check("post_rst_mode", 8'(mode), 8'(ST_SPLASH));

`ifdef BOARD_COMPOSITOR_BLINK_EN
    g_state = 2'd0;
    cursor_col = 4'd0;
    cursor_row = 4'd0;
    step(8'd0, 7'd0, SPL, "blink_latch");
    start = 1'b1;
    step(8'd5, 7'd5, NOCHK, "");
    start = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      step(8'd0, 7'd0, NOCHK, "");
      step(8'd32, 7'd17, (((f / 2) % 2) == 0) ? SPR : BG, $sformatf("blink_f%0d", f));
    end
    cursor_col = 4'd1;
    step(8'd0, 7'd0, NOCHK, "");
    step(8'd38, 7'd17, SPR, "blink_move");
`endif

    step(8'd1, 7'd1, NOCHK, "");
    step(8'd1, 7'd1, NOCHK, "");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
